// File: rtl/red_pitaya_daisy_pkg.sv
// Shared definitions for the daisy-chain link: controller state encoding,
// TX source selector codes and the registered control-output bundle.
package red_pitaya_daisy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_TRAIN   = 3'd2,
        ST_VERIFY  = 3'd3,
        ST_UP      = 3'd4,
        ST_BACKOFF = 3'd5,
        ST_FAIL    = 3'd6
    } link_state_t;

    localparam logic [2:0] TXSEL_IDLE  = 3'd0;
    localparam logic [2:0] TXSEL_DATA  = 3'd1;
    localparam logic [2:0] TXSEL_TRAIN = 3'd3;
    localparam logic [2:0] TXSEL_TEST  = 3'd5;

    localparam logic [3:0] RETRY_SAT = 4'd15;

    typedef struct packed {
        logic       tx_en;
        logic       rx_en;
        logic       rx_train;
        logic       tst_clr;
        logic [2:0] tx_sel;
        logic       link_up;
        logic       link_fail;
    } link_ctl_t;

    // Control outputs are a pure function of the state being entered.
    function automatic link_ctl_t state_outputs(input link_state_t st);
        link_ctl_t o;
        o = '0;
        case (st)
            ST_SETTLE: begin
                o.tx_en   = 1'b1;
                o.rx_en   = 1'b1;
                o.tst_clr = 1'b1;
                o.tx_sel  = TXSEL_TRAIN;
            end
            ST_TRAIN: begin
                o.tx_en    = 1'b1;
                o.rx_en    = 1'b1;
                o.rx_train = 1'b1;
                o.tst_clr  = 1'b1;
                o.tx_sel   = TXSEL_TRAIN;
            end
            ST_VERIFY: begin
                o.tx_en  = 1'b1;
                o.rx_en  = 1'b1;
                o.tx_sel = TXSEL_TEST;
            end
            ST_UP: begin
                o.tx_en   = 1'b1;
                o.rx_en   = 1'b1;
                o.tst_clr = 1'b1;
                o.tx_sel  = TXSEL_DATA;
                o.link_up = 1'b1;
            end
            ST_FAIL: begin
                o.link_fail = 1'b1;
            end
            default: begin
                o = '0;
            end
        endcase
        return o;
    endfunction

    function automatic logic [3:0] retry_inc(input logic [3:0] r);
        return (r == RETRY_SAT) ? r : r + 4'd1;
    endfunction

endpackage

// File: rtl/red_pitaya_daisy_link_ctrl.sv
// Daisy-chain link bring-up sequencer: settle, train, PRBS verify, then
// declare the link up, retrying a bounded number of times before failing.
module red_pitaya_daisy_link_ctrl
    import red_pitaya_daisy_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 256,
    parameter int unsigned TRAIN_TO   = 65536,
    parameter int unsigned VERIFY_CYC = 4096,
    parameter int unsigned MIN_DAT    = 16,
    parameter int unsigned MAX_RETRY  = 3,
    parameter int unsigned CW         = 20
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    input  logic        ctl_start_i,
    input  logic        ctl_stop_i,
    input  logic        rx_trained_i,
    input  logic [31:0] tst_err_cnt_i,
    input  logic [31:0] tst_dat_cnt_i,
    output logic        cfg_tx_en_o,
    output logic        cfg_rx_en_o,
    output logic        cfg_rx_train_o,
    output logic        cfg_tst_clr_o,
    output logic [2:0]  tx_sel_o,
    output logic        link_up_o,
    output logic        link_fail_o,
    output logic [2:0]  state_o,
    output logic [3:0]  retry_cnt_o
);

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] TRAIN_LAST  = CW'(TRAIN_TO - 1);
    localparam logic [CW-1:0] VERIFY_LAST = CW'(VERIFY_CYC - 1);
    localparam logic [31:0]   MIN_DAT_32  = 32'(MIN_DAT);
    localparam logic [3:0]    RETRY_LIMIT = 4'(MAX_RETRY);

    link_state_t   r_state;
    link_state_t   w_state_nxt;
    logic [CW-1:0] r_timer;
    logic [CW-1:0] w_timer_nxt;
    logic [3:0]    r_retry;
    logic [3:0]    w_retry_nxt;
    link_ctl_t     r_ctl;
    link_ctl_t     w_ctl_nxt;
    logic          w_timed_state;

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_retry <= '0;
            r_ctl   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_retry <= w_retry_nxt;
            r_ctl   <= w_ctl_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_retry_nxt = r_retry;

        unique case (r_state)
            ST_IDLE: begin
                if (ctl_start_i) begin
                    w_state_nxt = ST_SETTLE;
                    w_retry_nxt = '0;
                end
            end
            ST_SETTLE: begin
                if (r_timer == SETTLE_LAST) begin
                    w_state_nxt = ST_TRAIN;
                end
            end
            ST_TRAIN: begin
                if (rx_trained_i) begin
                    w_state_nxt = ST_VERIFY;
                end else if (r_timer == TRAIN_LAST) begin
                    w_state_nxt = ST_BACKOFF;
                end
            end
            ST_VERIFY: begin
                if (tst_err_cnt_i != 32'd0) begin
                    w_state_nxt = ST_BACKOFF;
                end else if (r_timer == VERIFY_LAST) begin
                    w_state_nxt = (tst_dat_cnt_i >= MIN_DAT_32) ? ST_UP : ST_BACKOFF;
                end
            end
            ST_UP: begin
                if (!rx_trained_i) begin
                    w_state_nxt = ST_BACKOFF;
                end
            end
            ST_BACKOFF: begin
                w_state_nxt = (r_retry >= RETRY_LIMIT) ? ST_FAIL : ST_SETTLE;
            end
            ST_FAIL: begin
                if (ctl_start_i) begin
                    w_state_nxt = ST_SETTLE;
                    w_retry_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Stop overrides everything, including a simultaneous start.
        if (ctl_stop_i) begin
            w_state_nxt = ST_IDLE;
            w_retry_nxt = r_retry;
        end

        if ((w_state_nxt == ST_BACKOFF) && (r_state != ST_BACKOFF)) begin
            w_retry_nxt = retry_inc(r_retry);
        end
    end

    always_comb begin
        w_timed_state = (r_state == ST_SETTLE) || (r_state == ST_TRAIN) ||
                        (r_state == ST_VERIFY);
        if (w_state_nxt != r_state) begin
            w_timer_nxt = '0;
        end else if (w_timed_state) begin
            w_timer_nxt = r_timer + 1'b1;
        end else begin
            w_timer_nxt = '0;
        end
        w_ctl_nxt = state_outputs(w_state_nxt);
    end

    assign cfg_tx_en_o    = r_ctl.tx_en;
    assign cfg_rx_en_o    = r_ctl.rx_en;
    assign cfg_rx_train_o = r_ctl.rx_train;
    assign cfg_tst_clr_o  = r_ctl.tst_clr;
    assign tx_sel_o       = r_ctl.tx_sel;
    assign link_up_o      = r_ctl.link_up;
    assign link_fail_o    = r_ctl.link_fail;
    assign state_o        = r_state;
    assign retry_cnt_o    = r_retry;

endmodule

// File: tb/tb_red_pitaya_daisy_link_ctrl.sv
// Scenario bench for the daisy link sequencer; expected timing is derived
// from phase lengths, expected outputs from the per-state output table.
module tb_red_pitaya_daisy_link_ctrl;

    localparam int unsigned S   = 8;
    localparam int unsigned TTO = 32;
    localparam int unsigned V   = 64;
    localparam int unsigned MD  = 16;
    localparam int unsigned MR  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        trained = 1'b0;
    logic [31:0] err = 32'd0;
    logic [31:0] dat = 32'd0;

    logic        tx_en, rx_en, rx_train, tst_clr, link_up, link_fail;
    logic [2:0]  tx_sel, state;
    logic [3:0]  retry;
    logic [8:0]  outs;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    assign outs = {tx_en, rx_en, rx_train, tst_clr, tx_sel, link_up, link_fail};

    red_pitaya_daisy_link_ctrl #(
        .SETTLE_CYC(S), .TRAIN_TO(TTO), .VERIFY_CYC(V),
        .MIN_DAT(MD), .MAX_RETRY(MR), .CW(20)
    ) dut (
        .sys_clk_i      (clk),
        .sys_rst_i      (rst),
        .ctl_start_i    (start),
        .ctl_stop_i     (stop),
        .rx_trained_i   (trained),
        .tst_err_cnt_i  (err),
        .tst_dat_cnt_i  (dat),
        .cfg_tx_en_o    (tx_en),
        .cfg_rx_en_o    (rx_en),
        .cfg_rx_train_o (rx_train),
        .cfg_tst_clr_o  (tst_clr),
        .tx_sel_o       (tx_sel),
        .link_up_o      (link_up),
        .link_fail_o    (link_fail),
        .state_o        (state),
        .retry_cnt_o    (retry)
    );

    // Output table per state: {tx_en, rx_en, rx_train, tst_clr, tx_sel, link_up, link_fail}
    function automatic logic [8:0] exp_outs(input int st);
        case (st)
            1: return {4'b1101, 3'd3, 2'b00};
            2: return {4'b1111, 3'd3, 2'b00};
            3: return {4'b1100, 3'd5, 2'b00};
            4: return {4'b1101, 3'd1, 2'b10};
            6: return {4'b0000, 3'd0, 2'b01};
            default: return 9'd0;
        endcase
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step(1);
        stop = 1'b0;
    endtask

    // From the first SETTLE cycle: wait out SETTLE, then d TRAIN cycles, then report trained.
    task automatic drive_to_verify(input int d);
        step(S);
        step(d);
        trained = 1'b1;
        step(1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        total++; if (state !== 3'd0) begin bad++; $display("[TB] FAIL reset_state: got %0d want 0", state); end
        total++; if (outs !== 9'd0) begin bad++; $display("[TB] FAIL reset_outs: got %b want %b", outs, 9'd0); end
        total++; if (retry !== 4'd0) begin bad++; $display("[TB] FAIL reset_retry: got %0d want 0", retry); end
        rst = 1'b0;
        step(1);
        total++; if (state !== 3'd0) begin bad++; $display("[TB] FAIL reset_idle_hold: got %0d want 0", state); end
    endtask

    task automatic test_nominal();
        int d;
        int n;
        d = $urandom_range(1, 30);
        dat = $urandom_range(MD, 5000);
        err = 32'd0;
        trained = 1'b0;
        start = 1'b1;
        step(1);
        start = 1'b0;
        n = 1;
        total++; if (state !== 3'd1) begin bad++; $display("[TB] FAIL nom_settle_state: got %0d want 1", state); end
        total++; if (outs !== exp_outs(1)) begin bad++; $display("[TB] FAIL nom_settle_outs: got %b want %b", outs, exp_outs(1)); end
        while (rx_train !== 1'b1 && n < int'(S) + 10) begin
            step(1);
            n++;
        end
        total++; if (n != int'(S) + 1) begin bad++; $display("[TB] FAIL nom_train_latency: got %0d want %0d", n, S + 1); end
        total++; if (outs !== exp_outs(2)) begin bad++; $display("[TB] FAIL nom_train_outs: got %b want %b", outs, exp_outs(2)); end
        step(d);
        trained = 1'b1;
        step(1);
        total++; if (outs !== exp_outs(3) || state !== 3'd3) begin bad++; $display("[TB] FAIL nom_verify: got st=%0d outs=%b want st=3 outs=%b", state, outs, exp_outs(3)); end
        step(V - 1);
        total++; if (state !== 3'd3) begin bad++; $display("[TB] FAIL nom_verify_len: got %0d want 3", state); end
        step(1);
        total++; if (outs !== exp_outs(4) || state !== 3'd4) begin bad++; $display("[TB] FAIL nom_up: got st=%0d outs=%b want st=4 outs=%b", state, outs, exp_outs(4)); end
        total++; if (retry !== 4'd0) begin bad++; $display("[TB] FAIL nom_retry: got %0d want 0", retry); end
        trained = 1'b0;
        pulse_stop();
        total++; if (state !== 3'd0 || outs !== 9'd0) begin bad++; $display("[TB] FAIL nom_stop: got st=%0d outs=%b want st=0 outs=0", state, outs); end
    endtask

    task automatic test_train_tie();
        trained = 1'b0;
        dat = 32'd100;
        pulse_start();
        drive_to_verify(TTO - 1);
        total++; if (state !== 3'd3) begin bad++; $display("[TB] FAIL tie_trained_wins: got %0d want 3", state); end
        trained = 1'b0;
        pulse_stop();
    endtask

    task automatic test_train_timeout();
        int n;
        int nb;
        int bound;
        logic [2:0] prev;
        trained = 1'b0;
        bound = 4 * int'(S + TTO + 1) + 10;
        pulse_start();
        n = 1;
        nb = 0;
        prev = state;
        while (state !== 3'd6 && n < bound) begin
            step(1);
            n++;
            if (state === 3'd5 && prev !== 3'd5) begin
                nb++;
                total++; if (retry !== 4'(nb)) begin bad++; $display("[TB] FAIL to_backoff_retry: got %0d want %0d", retry, nb); end
                total++; if (outs !== 9'd0) begin bad++; $display("[TB] FAIL to_backoff_outs: got %b want 0", outs); end
            end
            prev = state;
        end
        total++; if (n != 3 * int'(S + TTO + 1) + 1) begin bad++; $display("[TB] FAIL to_fail_time: got %0d want %0d", n, 3 * (S + TTO + 1) + 1); end
        total++; if (nb != 3) begin bad++; $display("[TB] FAIL to_backoff_count: got %0d want 3", nb); end
        total++; if (state !== 3'd6 || outs !== exp_outs(6)) begin bad++; $display("[TB] FAIL to_fail_state: got st=%0d outs=%b want st=6 outs=%b", state, outs, exp_outs(6)); end
        total++; if (retry !== 4'd3) begin bad++; $display("[TB] FAIL to_fail_retry: got %0d want 3", retry); end
    endtask

    task automatic test_verify_error();
        dat = 32'd100;
        err = 32'd0;
        trained = 1'b0;
        pulse_start();
        total++; if (state !== 3'd1 || link_fail !== 1'b0 || retry !== 4'd0) begin bad++; $display("[TB] FAIL err_restart: got st=%0d fail=%b retry=%0d want 1/0/0", state, link_fail, retry); end
        drive_to_verify($urandom_range(0, 20));
        total++; if (state !== 3'd3) begin bad++; $display("[TB] FAIL err_verify_entry: got %0d want 3", state); end
        step(4);
        err = $urandom | 32'd1;
        step(1);
        total++; if (state !== 3'd5 || outs !== 9'd0) begin bad++; $display("[TB] FAIL err_backoff: got st=%0d outs=%b want st=5 outs=0", state, outs); end
        total++; if (retry !== 4'd1) begin bad++; $display("[TB] FAIL err_retry: got %0d want 1", retry); end
        err = 32'd0;
        step(1);
        total++; if (state !== 3'd1 || outs !== exp_outs(1)) begin bad++; $display("[TB] FAIL err_resettle: got st=%0d outs=%b want st=1 outs=%b", state, outs, exp_outs(1)); end
        trained = 1'b0;
        pulse_stop();
    endtask

    task automatic test_verify_starvation();
        logic [31:0] vals [4];
        int want;
        vals[0] = 32'd15;
        vals[1] = 32'd16;
        vals[2] = 32'($urandom_range(0, 15));
        vals[3] = $urandom | 32'h8000_0000;
        err = 32'd0;
        for (int i = 0; i < 4; i++) begin
            trained = 1'b0;
            dat = vals[i];
            pulse_start();
            drive_to_verify($urandom_range(0, 20));
            step(V);
            want = (vals[i] >= 32'(MD)) ? 4 : 5;
            total++; if (int'(state) != want) begin bad++; $display("[TB] FAIL starve_dat_%0h: got %0d want %0d", vals[i], state, want); end
            trained = 1'b0;
            pulse_stop();
        end
    endtask

    task automatic test_link_loss();
        trained = 1'b0;
        dat = 32'd200;
        err = 32'd0;
        pulse_start();
        drive_to_verify($urandom_range(0, 20));
        step(V);
        total++; if (state !== 3'd4) begin bad++; $display("[TB] FAIL loss_up: got %0d want 4", state); end
        step($urandom_range(1, 10));
        total++; if (link_up !== 1'b1) begin bad++; $display("[TB] FAIL loss_hold: got %b want 1", link_up); end
        trained = 1'b0;
        step(1);
        total++; if (state !== 3'd5 || link_up !== 1'b0) begin bad++; $display("[TB] FAIL loss_backoff: got st=%0d up=%b want st=5 up=0", state, link_up); end
        total++; if (retry !== 4'd1) begin bad++; $display("[TB] FAIL loss_retry: got %0d want 1", retry); end
        trained = 1'b1;
        step(1 + S + V);
        total++; if (state !== 3'd3) begin bad++; $display("[TB] FAIL loss_reverify: got %0d want 3", state); end
        step(1);
        total++; if (state !== 3'd4 || link_up !== 1'b1) begin bad++; $display("[TB] FAIL loss_recover: got st=%0d up=%b want st=4 up=1", state, link_up); end
        trained = 1'b0;
        pulse_stop();
    endtask

    task automatic test_stop_priority();
        trained = 1'b0;
        pulse_start();
        step(3);
        pulse_start();
        step(S - 4);
        total++; if (state !== 3'd2) begin bad++; $display("[TB] FAIL stop_start_ignored: got %0d want 2", state); end
        start = 1'b1;
        stop = 1'b1;
        step(1);
        start = 1'b0;
        stop = 1'b0;
        total++; if (state !== 3'd0 || outs !== 9'd0) begin bad++; $display("[TB] FAIL stop_in_train: got st=%0d outs=%b want st=0 outs=0", state, outs); end
        start = 1'b1;
        stop = 1'b1;
        step(1);
        start = 1'b0;
        stop = 1'b0;
        total++; if (state !== 3'd0) begin bad++; $display("[TB] FAIL stop_in_idle: got %0d want 0", state); end
    endtask

    task automatic test_reset_mid();
        trained = 1'b0;
        dat = 32'd100;
        pulse_start();
        drive_to_verify($urandom_range(0, 20));
        total++; if (state !== 3'd3) begin bad++; $display("[TB] FAIL rstmid_verify: got %0d want 3", state); end
        step($urandom_range(1, V - 2));
        rst = 1'b1;
        step(1);
        total++; if (state !== 3'd0 || outs !== 9'd0 || retry !== 4'd0) begin bad++; $display("[TB] FAIL rstmid_outs: got st=%0d outs=%b retry=%0d want all 0", state, outs, retry); end
        rst = 1'b0;
        trained = 1'b0;
        step(1);
        total++; if (state !== 3'd0) begin bad++; $display("[TB] FAIL rstmid_after: got %0d want 0", state); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_train_tie();
        test_train_timeout();
        test_verify_error();
        test_verify_starvation();
        test_link_loss();
        test_stop_priority();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
